// File: rtl/dmem_if.sv
// dmem_if: MEM-stage data bus between the pipeline (master) and the data memory
// responder (slave), carrying the request fields and the dready_n/dbusy handshake.
`timescale 1ns/1ps
interface dmem_if;
    logic [1:0]  MemRW;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [1:0]  dsize;
    logic [31:0] drdata;
    logic        dready_n;
    logic        dbusy;
    logic        derr;

    modport master (
        output MemRW, daddr, dwdata, dsize,
        input  drdata, dready_n, dbusy, derr
    );

    modport slave (
        input  MemRW, daddr, dwdata, dsize,
        output drdata, dready_n, dbusy, derr
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with fixed read latency and a one-entry
// posted store buffer. Optional macro DMEM_RAW_FWD_EN enables full-word store-to-load forwarding.
//
// state     | meaning
// S_IDLE    | accepting requests; loads wait here while a store is buffered
// S_RD_WAIT | read latency countdown (r_cnt down to 0)
// S_RD_DONE | drdata valid, dready_n low for this single cycle
`timescale 1ns/1ps
module dmem_responder #(
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 3
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);

    localparam int RCNT_W = (READ_LAT  > 1) ? $clog2(READ_LAT)  : 1;
    localparam int WCNT_W = (WRITE_LAT > 1) ? $clog2(WRITE_LAT) : 1;
    localparam logic [RCNT_W-1:0] RD_CNT_INIT = (READ_LAT > 1) ? RCNT_W'(READ_LAT - 2) : '0;
    localparam logic [WCNT_W-1:0] WR_CNT_INIT = WCNT_W'(WRITE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_RD_DONE = 2'd2
    } rd_state_t;

    rd_state_t          r_state;
    rd_state_t          w_state_nxt;
    logic [RCNT_W-1:0]  r_cnt;
    logic [RCNT_W-1:0]  w_cnt_nxt;
    logic [31:0]        r_drdata;
    logic               r_derr;

    logic               r_wb_valid;
    logic [WCNT_W-1:0]  r_wb_cnt;
    logic [ADDR_W-1:0]  r_wb_addr;
    logic [31:0]        r_wb_data;
    logic [3:0]         r_wb_be;

    logic [31:0]        r_mem [0:(2**ADDR_W)-1];

    logic [ADDR_W-1:0]  w_word;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_misalign;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic               w_fwd_hit;
    logic               w_commit;
    logic               w_rd_mem;
    logic               w_rd_fwd;
    logic               w_st_accept;
    logic               w_err;
    logic               w_unused;

    assign w_word     = bus.daddr[ADDR_W+1:2];
    assign w_is_load  = bus.MemRW[1];
    assign w_is_store = (bus.MemRW == 2'b01);
    assign w_commit   = r_wb_valid && (r_wb_cnt == '0);
    assign w_unused   = &{1'b0, bus.daddr[31:ADDR_W+2]};

    // Store data is replicated across lanes; the byte enables pick the live lanes.
    always_comb begin
        w_misalign = 1'b0;
        w_be       = 4'b0000;
        w_wdata    = bus.dwdata;
        case (bus.dsize)
            2'b00: begin
                w_be    = 4'b0001 << bus.daddr[1:0];
                w_wdata = {4{bus.dwdata[7:0]}};
            end
            2'b01: begin
                w_misalign = bus.daddr[0];
                w_be       = bus.daddr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{bus.dwdata[15:0]}};
            end
            2'b10: begin
                w_misalign = |bus.daddr[1:0];
                w_be       = 4'b1111;
            end
            default: begin
                w_misalign = 1'b1;
            end
        endcase
    end

`ifdef DMEM_RAW_FWD_EN
    assign w_fwd_hit = r_wb_valid && (r_wb_addr == w_word) && (r_wb_be == 4'b1111);
`else
    assign w_fwd_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rd_mem    = 1'b0;
        w_rd_fwd    = 1'b0;
        w_st_accept = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_load) begin
                    // MemRW=11 lands here too: served as a load, flagged as illegal.
                    if (!r_wb_valid) begin
                        w_err = w_misalign || bus.MemRW[0];
                        if (READ_LAT > 1) begin
                            w_state_nxt = S_RD_WAIT;
                            w_cnt_nxt   = RD_CNT_INIT;
                        end else begin
                            w_state_nxt = S_RD_DONE;
                            w_rd_mem    = 1'b1;
                        end
                    end else if (w_fwd_hit) begin
                        w_err       = w_misalign || bus.MemRW[0];
                        w_state_nxt = S_RD_DONE;
                        w_rd_fwd    = 1'b1;
                    end
                end else if (w_is_store && !r_wb_valid) begin
                    if (w_misalign) begin
                        w_err = 1'b1;
                    end else begin
                        w_st_accept = 1'b1;
                    end
                end
            end
            S_RD_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RD_DONE;
                    w_rd_mem    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - RCNT_W'(1);
                end
            end
            S_RD_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_drdata <= '0;
            r_derr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_derr  <= w_err;
            if (w_rd_fwd) begin
                r_drdata <= r_wb_data;
            end else if (w_rd_mem) begin
                r_drdata <= r_mem[w_word];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid <= 1'b0;
            r_wb_cnt   <= '0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_wb_be    <= 4'b0000;
        end else if (w_st_accept) begin
            r_wb_valid <= 1'b1;
            r_wb_cnt   <= WR_CNT_INIT;
            r_wb_addr  <= w_word;
            r_wb_data  <= w_wdata;
            r_wb_be    <= w_be;
        end else if (r_wb_valid) begin
            if (r_wb_cnt == '0) begin
                r_wb_valid <= 1'b0;
            end else begin
                r_wb_cnt <= r_wb_cnt - WCNT_W'(1);
            end
        end
    end

    // Memory contents survive reset; the store buffer is cleared so nothing commits.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wb_be[b]) begin
                    r_mem[r_wb_addr][8*b +: 8] <= r_wb_data[8*b +: 8];
                end
            end
        end
    end

    assign bus.drdata   = r_drdata;
    assign bus.dready_n = (r_state != S_RD_DONE);
    assign bus.dbusy    = r_wb_valid;
    assign bus.derr     = r_derr;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against a
// transaction-level model (memory array, one pending store, latency arithmetic).
`timescale 1ns/1ps
module tb_dmem_responder;
    localparam int RL = 2;
    localparam int WL = 3;
`ifdef DMEM_RAW_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    dmem_if bus();

    dmem_responder #(.ADDR_W(10), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic        s_rdy_n, s_busy, s_err;
    logic [31:0] s_data;
    int          s_cyc;
    int          n_busy, n_rdy;
    int          obs_err_q[$];
    int          exp_err_q[$];
    int          obs_acc, obs_done;
    logic [31:0] obs_data;
    logic        obs_busy_done;

    // Reference model: memory image plus the single store awaiting commit.
    logic [31:0] ref_mem [0:1023];
    bit          p_valid;
    int          p_word;
    logic [31:0] p_data;
    logic [3:0]  p_be;
    int          p_commit;
    int          exp_busy;

    function automatic bit illegal_size(input logic [31:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            2'b10:   return (a[1:0] != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    task automatic m_sync(input int c);
        if (p_valid && c > p_commit) begin
            for (int b = 0; b < 4; b++)
                if (p_be[b]) ref_mem[p_word][8*b +: 8] = p_data[8*b +: 8];
            p_valid = 1'b0;
        end
    endtask

    task automatic m_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input int t0, output int acc);
        m_sync(t0);
        acc = (p_valid && t0 <= p_commit) ? p_commit + 1 : t0;
        m_sync(acc);
        if (illegal_size(a, sz)) begin
            exp_err_q.push_back(acc + 1);
        end else begin
            p_valid  = 1'b1;
            p_word   = int'(a[11:2]);
            p_commit = acc + WL;
            exp_busy += WL;
            case (sz)
                2'b00:   begin p_be = 4'b0001 << a[1:0]; p_data = 32'(d[7:0]) << (8 * a[1:0]); end
                2'b01:   begin p_be = 4'b0011 << {a[1], 1'b0}; p_data = 32'(d[15:0]) << (16 * a[1]); end
                default: begin p_be = 4'b1111; p_data = d; end
            endcase
        end
    endtask

    task automatic m_load(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] rw,
                          input int t0, output int done, output logic [31:0] data);
        bit err;
        int start;
        m_sync(t0);
        err = illegal_size(a, sz) || (rw == 2'b11);
        if (FWD && p_valid && t0 <= p_commit && p_word == int'(a[11:2]) && p_be == 4'hF) begin
            done = t0 + 1;
            data = p_data;
            if (err) exp_err_q.push_back(t0 + 1);
        end else begin
            start = (p_valid && t0 <= p_commit) ? p_commit + 1 : t0;
            m_sync(start);
            done = start + RL;
            data = ref_mem[a[11:2]];
            if (err) exp_err_q.push_back(start + 1);
        end
    endtask

    task automatic step();
        @(negedge clk);
        s_rdy_n = bus.dready_n;
        s_busy  = bus.dbusy;
        s_err   = bus.derr;
        s_data  = bus.drdata;
        s_cyc   = cyc;
        if (s_busy === 1'b1) n_busy++;
        if (s_rdy_n === 1'b0) n_rdy++;
        if (s_err === 1'b1) obs_err_q.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bus.MemRW = 2'b00;
        repeat (n) step();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bus.MemRW = 2'b01; bus.daddr = a; bus.dwdata = d; bus.dsize = sz;
        obs_acc = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_busy === 1'b0) begin obs_acc = s_cyc; break; end
        end
        bus.MemRW = 2'b00;
        if (obs_acc < 0) begin
            checks++; failures++;
            $display("FAIL store_timeout addr=%h: dbusy never 0 within 40 cycles", a);
        end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] rw);
        bus.MemRW = rw; bus.daddr = a; bus.dwdata = 32'hFFFF_FFFF; bus.dsize = sz;
        obs_done = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_rdy_n === 1'b0) begin
                obs_done = s_cyc; obs_data = s_data; obs_busy_done = s_busy; break;
            end
        end
        bus.MemRW = 2'b00;
        if (obs_done < 0) begin
            checks++; failures++;
            $display("FAIL load_timeout addr=%h: dready_n never 0 within 40 cycles", a);
        end
    endtask

    task automatic start_test();
        idle(WL + 2);
        m_sync(cyc);
        n_busy = 0; n_rdy = 0; exp_busy = 0;
        obs_err_q.delete(); exp_err_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.dready_n !== 1'b1) begin failures++; $display("FAIL reset_dready_n got=%b exp=1", bus.dready_n); end
        checks++; if (bus.dbusy !== 1'b0) begin failures++; $display("FAIL reset_dbusy got=%b exp=0", bus.dbusy); end
        checks++; if (bus.derr !== 1'b0) begin failures++; $display("FAIL reset_derr got=%b exp=0", bus.derr); end
        checks++; if (bus.drdata !== 32'h0) begin failures++; $display("FAIL reset_drdata got=%h exp=0", bus.drdata); end
        @(posedge clk); #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic test_store_load();
        int acc, done, t0;
        logic [31:0] ed;
        start_test();
        t0 = cyc;
        m_store(32'h40, 32'hDEAD_BEEF, 2'b10, t0, acc);
        do_store(32'h40, 32'hDEAD_BEEF, 2'b10);
        checks++; if (obs_acc != t0) begin failures++; $display("FAIL sl_accept got=%0d exp=%0d", obs_acc, t0); end
        m_load(32'h40, 2'b10, 2'b10, cyc, done, ed);
        do_load(32'h40, 2'b10, 2'b10);
        checks++; if (obs_done - obs_acc != (FWD ? 2 : 6)) begin failures++; $display("FAIL sl_latency got=%0d exp=%0d", obs_done - obs_acc, FWD ? 2 : 6); end
        checks++; if (obs_done != done) begin failures++; $display("FAIL sl_done_model got=%0d exp=%0d", obs_done, done); end
        checks++; if (obs_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sl_data got=%h exp=deadbeef", obs_data); end
        idle(WL + 2);
        checks++; if (n_busy != 3) begin failures++; $display("FAIL sl_busy_cycles got=%0d exp=3", n_busy); end
        checks++; if (n_rdy != 1) begin failures++; $display("FAIL sl_ready_cycles got=%0d exp=1", n_rdy); end
        checks++; if (obs_err_q.size() != 0) begin failures++; $display("FAIL sl_derr got=%0d pulses exp=0", obs_err_q.size()); end
    endtask

    task automatic test_byte_stores();
        int acc, done;
        logic [31:0] ed;
        start_test();
        m_store(32'h80, 32'h0, 2'b10, cyc, acc);    do_store(32'h80, 32'h0, 2'b10);
        checks++; if (obs_acc != acc) begin failures++; $display("FAIL bs_acc0 got=%0d exp=%0d", obs_acc, acc); end
        m_store(32'h81, 32'h11, 2'b00, cyc, acc);   do_store(32'h81, 32'h11, 2'b00);
        checks++; if (obs_acc != acc) begin failures++; $display("FAIL bs_acc1 got=%0d exp=%0d", obs_acc, acc); end
        m_store(32'h83, 32'h22, 2'b00, cyc, acc);   do_store(32'h83, 32'h22, 2'b00);
        checks++; if (obs_acc != acc) begin failures++; $display("FAIL bs_acc2 got=%0d exp=%0d", obs_acc, acc); end
        m_load(32'h80, 2'b10, 2'b10, cyc, done, ed);
        do_load(32'h80, 2'b10, 2'b10);
        checks++; if (obs_data !== 32'h2200_1100) begin failures++; $display("FAIL bs_data got=%h exp=22001100", obs_data); end
        checks++; if (obs_done != done) begin failures++; $display("FAIL bs_done got=%0d exp=%0d", obs_done, done); end
    endtask

    task automatic test_back_to_back();
        int acc, done, t;
        logic [31:0] ed;
        m_store(32'h44, 32'h4444_4444, 2'b10, cyc, acc);
        do_store(32'h44, 32'h4444_4444, 2'b10);
        start_test();
        t = cyc;
        m_load(32'h40, 2'b10, 2'b10, cyc, done, ed);
        do_load(32'h40, 2'b10, 2'b10);
        checks++; if (obs_done != t + 2) begin failures++; $display("FAIL b2b_done0 got=%0d exp=%0d", obs_done, t + 2); end
        checks++; if (obs_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b_data0 got=%h exp=deadbeef", obs_data); end
        m_load(32'h44, 2'b10, 2'b10, cyc, done, ed);
        do_load(32'h44, 2'b10, 2'b10);
        checks++; if (obs_done != t + 5) begin failures++; $display("FAIL b2b_done1 got=%0d exp=%0d", obs_done, t + 5); end
        checks++; if (obs_data !== 32'h4444_4444) begin failures++; $display("FAIL b2b_data1 got=%h exp=44444444", obs_data); end
    endtask

    task automatic test_misaligned();
        int acc, done;
        logic [31:0] ed;
        start_test();
        m_store(32'h42, 32'hBAD0_BAD0, 2'b10, cyc, acc);
        do_store(32'h42, 32'hBAD0_BAD0, 2'b10);
        idle(2);
        checks++; if (obs_err_q.size() != 1 || obs_err_q[0] != acc + 1) begin failures++; $display("FAIL mis_store_derr got=%0d pulses exp=1 at %0d", obs_err_q.size(), acc + 1); end
        m_store(32'h41, 32'h7777, 2'b01, cyc, acc); do_store(32'h41, 32'h7777, 2'b01);
        m_store(32'h40, 32'h9999, 2'b11, cyc, acc); do_store(32'h40, 32'h9999, 2'b11);
        idle(2);
        checks++; if (n_busy != 0) begin failures++; $display("FAIL mis_busy got=%0d exp=0", n_busy); end
        m_load(32'h40, 2'b10, 2'b10, cyc, done, ed); do_load(32'h40, 2'b10, 2'b10);
        checks++; if (obs_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mis_unchanged got=%h exp=deadbeef", obs_data); end
        m_load(32'h46, 2'b10, 2'b10, cyc, done, ed); do_load(32'h46, 2'b10, 2'b10);
        checks++; if (obs_data !== 32'h4444_4444) begin failures++; $display("FAIL mis_load_aligned got=%h exp=44444444", obs_data); end
        m_load(32'h40, 2'b10, 2'b11, cyc, done, ed); do_load(32'h40, 2'b10, 2'b11);
        checks++; if (obs_data !== 32'hDEAD_BEEF || obs_done != done) begin failures++; $display("FAIL mis_rw11 got=%h@%0d exp=deadbeef@%0d", obs_data, obs_done, done); end
        idle(WL + 2);
        checks++; if (n_busy != 0) begin failures++; $display("FAIL mis_rw11_busy got=%0d exp=0", n_busy); end
        checks++;
        if (obs_err_q.size() != exp_err_q.size()) begin
            failures++; $display("FAIL mis_derr_count got=%0d exp=%0d", obs_err_q.size(), exp_err_q.size());
        end else begin
            foreach (exp_err_q[i]) begin
                checks++;
                if (obs_err_q[i] != exp_err_q[i]) begin failures++; $display("FAIL mis_derr_cycle got=%0d exp=%0d", obs_err_q[i], exp_err_q[i]); end
            end
        end
    endtask

    task automatic test_reset_pending();
        int acc, done;
        logic [31:0] ed;
        start_test();
        m_store(32'h10, 32'h1234_5678, 2'b10, cyc, acc); do_store(32'h10, 32'h1234_5678, 2'b10);
        idle(WL + 2);
        m_store(32'h10, 32'h5, 2'b10, cyc, acc); do_store(32'h10, 32'h5, 2'b10);
        #2;
        checks++; if (bus.dbusy !== 1'b1) begin failures++; $display("FAIL rp_busy_before got=%b exp=1", bus.dbusy); end
        rst = 1'b0;
        #1;
        checks++; if (bus.dbusy !== 1'b0) begin failures++; $display("FAIL rp_busy_async got=%b exp=0", bus.dbusy); end
        checks++; if (bus.dready_n !== 1'b1) begin failures++; $display("FAIL rp_ready_async got=%b exp=1", bus.dready_n); end
        step(); step();
        rst = 1'b1;
        p_valid = 1'b0;
        step();
        m_load(32'h10, 2'b10, 2'b10, cyc, done, ed); do_load(32'h10, 2'b10, 2'b10);
        checks++; if (obs_data !== 32'h1234_5678) begin failures++; $display("FAIL rp_old_value got=%h exp=12345678", obs_data); end
        checks++; if (obs_done != done) begin failures++; $display("FAIL rp_done got=%0d exp=%0d", obs_done, done); end
    endtask

    task automatic test_raw_fwd();
        int acc, done;
        logic [31:0] ed;
        start_test();
        m_store(32'h20, 32'hCAFE_0001, 2'b10, cyc, acc); do_store(32'h20, 32'hCAFE_0001, 2'b10);
        m_load(32'h20, 2'b10, 2'b10, cyc, done, ed); do_load(32'h20, 2'b10, 2'b10);
        checks++; if (obs_done - obs_acc != (FWD ? 2 : 6)) begin failures++; $display("FAIL fwd_latency got=%0d exp=%0d", obs_done - obs_acc, FWD ? 2 : 6); end
        checks++; if (obs_data !== 32'hCAFE_0001) begin failures++; $display("FAIL fwd_data got=%h exp=cafe0001", obs_data); end
        checks++; if (obs_busy_done !== FWD) begin failures++; $display("FAIL fwd_busy_at_done got=%b exp=%b", obs_busy_done, FWD); end
        m_store(32'h21, 32'hAB, 2'b00, cyc, acc); do_store(32'h21, 32'hAB, 2'b00);
        m_load(32'h20, 2'b10, 2'b10, cyc, done, ed); do_load(32'h20, 2'b10, 2'b10);
        checks++; if (obs_done - obs_acc != 1 + WL + RL) begin failures++; $display("FAIL fwd_partial_wait got=%0d exp=%0d", obs_done - obs_acc, 1 + WL + RL); end
        checks++; if (obs_data !== 32'hCAFE_AB01) begin failures++; $display("FAIL fwd_partial_data got=%h exp=cafeab01", obs_data); end
    endtask

    task automatic test_random();
        int acc, done, loads;
        logic [31:0] ed, a, d;
        logic [1:0] sz, rw;
        start_test();
        loads = 0;
        for (int w = 0; w < 16; w++) begin
            a = 32'h100 + 32'(w * 4);
            d = $urandom;
            m_store(a, d, 2'b10, cyc, acc); do_store(a, d, 2'b10);
            checks++; if (obs_acc != acc) begin failures++; $display("FAIL rnd_init_acc got=%0d exp=%0d", obs_acc, acc); end
        end
        for (int k = 0; k < 60; k++) begin
            a  = 32'h100 + 32'($urandom_range(0, 15) * 4);
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (sz == 2'b00 || $urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
            else if (sz == 2'b01) a[1] = 1'($urandom_range(0, 1));
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                rw = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b10;
                m_load(a, sz, rw, cyc, done, ed);
                do_load(a, sz, rw);
                loads++;
                checks++; if (obs_done != done) begin failures++; $display("FAIL rnd_load_done addr=%h got=%0d exp=%0d", a, obs_done, done); end
                checks++; if (obs_data !== ed) begin failures++; $display("FAIL rnd_load_data addr=%h got=%h exp=%h", a, obs_data, ed); end
            end else begin
                m_store(a, d, sz, cyc, acc);
                do_store(a, d, sz);
                checks++; if (obs_acc != acc) begin failures++; $display("FAIL rnd_store_acc addr=%h got=%0d exp=%0d", a, obs_acc, acc); end
            end
            idle($urandom_range(0, 2));
        end
        idle(WL + 2);
        checks++; if (n_busy != exp_busy) begin failures++; $display("FAIL rnd_busy_cycles got=%0d exp=%0d", n_busy, exp_busy); end
        checks++; if (n_rdy != loads) begin failures++; $display("FAIL rnd_ready_cycles got=%0d exp=%0d", n_rdy, loads); end
        checks++;
        if (obs_err_q.size() != exp_err_q.size()) begin
            failures++; $display("FAIL rnd_derr_count got=%0d exp=%0d", obs_err_q.size(), exp_err_q.size());
        end else begin
            foreach (exp_err_q[i]) begin
                checks++;
                if (obs_err_q[i] != exp_err_q[i]) begin failures++; $display("FAIL rnd_derr_cycle got=%0d exp=%0d", obs_err_q[i], exp_err_q[i]); end
            end
        end
    endtask

    initial begin
        bus.MemRW = 2'b00; bus.daddr = '0; bus.dwdata = '0; bus.dsize = 2'b00;
        p_valid = 1'b0;
        test_reset();
        test_store_load();
        test_byte_stores();
        test_back_to_back();
        test_misaligned();
        test_reset_pending();
        test_raw_fwd();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the 5-stage pipeline's MEM stage; the memory side of the dready_n/dbusy handshake that the hazard/stall controller consumes.
- Services loads and stores from MemRW, with configurable read latency and a posted write buffer that has a configurable commit latency.
- Drives dready_n low for exactly one cycle when load data is valid, and raises dbusy while a posted store is committing.

Parameters:
- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W 32-bit words.
- READ_LAT, 2, read latency in cycles (>=1); the cycle the request is first seen to the dready_n=0 cycle.
- WRITE_LAT, 3, store commit latency in cycles (>=1); number of cycles dbusy is held at 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- MemRW  in  2  [1]=load, [0]=store; held stable by the pipeline while stalled.
- daddr  in  32  byte address; word index is daddr[ADDR_W+1:2].
- dwdata  in  32  store data, LSB-aligned.
- dsize  in  2  00=byte, 01=half, 10=word, 11=illegal.
- drdata  out  32  registered full aligned word; the pipeline performs extension.
- dready_n  out  1  0 = load data valid this cycle.
- dbusy  out  1  1 = store buffer occupied.
- derr  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (async, rst=0): read FSM IDLE; write buffer empty; drdata=0, dready_n=1, dbusy=0, derr=0. Any in-flight read or pending store is discarded. Memory contents are not cleared.
- Read FSM states: IDLE, RD_WAIT, RD_DONE.
- IDLE, MemRW[1]=1, no store pending:
  - READ_LAT>1: go to RD_WAIT with cnt=READ_LAT-2.
  - READ_LAT=1: go to RD_DONE.
- RD_WAIT: decrement cnt; at 0 go to RD_DONE. drdata is loaded from mem[word] on the edge entering RD_DONE.
- RD_DONE: dready_n=0 for this single cycle, then IDLE unconditionally. dready_n=1 in all other states.
- Timing: a load first seen in cycle T has dready_n=0 in cycle T+READ_LAT.
- Load with a store pending: the load waits in IDLE (dready_n=1) until the buffer empties, then starts. Loads never bypass an uncommitted store.
- Store accept: in IDLE, with MemRW=01, buffer empty and no read in flight:
  - Latch word address, shifted data and byte enables.
  - Byte enables: byte 0001<<a[1:0]; half 0011<<{a[1],0}; word 1111.
  - dbusy=1 from T+1 through T+WRITE_LAT.
  - The masked memory write happens on the edge ending T+WRITE_LAT; dbusy=0 at T+WRITE_LAT+1.
  - Accept-cycle dbusy=0, so the pipeline advances (posted store).
- A store arriving while dbusy=1 is not accepted and is held by pipeline stall.
- Illegal requests, each giving derr=1 for one cycle:
  - Misaligned half (a[0]=1), misaligned word (a[1:0]!=0) or dsize=11 store: dropped, dbusy stays 0.
  - MemRW=11: treated as a load, store half ignored.
  - Misaligned load: returns the aligned word.
- Repeats: if the pipeline re-presents the same request because of another stall source (e.g. iready_n), the request is re-serviced. Loads and stores are idempotent, so results are unaffected; only cycles are lost.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: DMEM_RAW_FWD_EN.
- Defined: a load seen in IDLE while a store is pending, with the same word index and byte enables 1111, goes directly to RD_DONE next cycle with drdata = buffered store data (load latency 1). The store commit continues unaffected. Partial-word matches still wait.
- Undefined: every load waits for the buffer to empty.

Test Plan:
- Store word 0xDEADBEEF @0x40, then load @0x40 (READ_LAT=2, WRITE_LAT=3) -> dbusy=1 for 3 cycles; load dready_n=0 exactly one cycle, drdata=0xDEADBEEF; store-to-load-done = 6 cycles (without macro).
- Byte stores 0x11@0x81, 0x22@0x83 over prior word 0 -> load @0x80 returns 0x22001100.
- Back-to-back loads @0x40, @0x44 -> dready_n low at T+2 and T+5 (IDLE gap); correct data each.
- Misaligned word store @0x42 -> derr pulse, dbusy stays 0, word @0x40 unchanged on later load.
- rst low while dbusy=1 (store 0x5 @0x10 pending) -> dready_n=1, dbusy=0 immediately; later load @0x10 returns the old value.
- With DMEM_RAW_FWD_EN: word store 0xCAFE0001 @0x20 then immediate load @0x20 -> dready_n=0 one cycle later, drdata=0xCAFE0001 while dbusy still 1.
